// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// Two registered read ports with a read-enable hold, and two write ports.
// Port 4 has priority over port 3 when both write the same register.
// Optional write-first bypass (BYPASS) and hardwired-zero x0 (ZERO_REG).
// Optional feature macro REGFILE_SCOREBOARD_EN: this adds per-register
// pending bits and the ISV/ISA inputs and HZ1/HZ2 hazard outputs.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RE,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic            ISV,
    input  logic [AW-1:0]   ISA,
    output logic            HZ1,
    output logic            HZ2,
`endif
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE4,
    input  logic [AW-1:0]   A4,
    input  logic [XLEN-1:0] WD4
);

    logic [XLEN-1:0] regs [NREGS];
    logic            w3_ok, w4_ok;
    logic [XLEN-1:0] rd1_next, rd2_next;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    // Addresses that hold real storage: in range and not the hardwired zero.
    function automatic logic live_addr(input logic [AW-1:0] a);
        return addr_ok(a) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [XLEN-1:0] read_sel(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            w3, input logic [AW-1:0] a3, input logic [XLEN-1:0] d3,
        input logic            w4, input logic [AW-1:0] a4, input logic [XLEN-1:0] d4
    );
        if (!live_addr(a))                 return '0;
        if (BYPASS && w4 && (a4 == a))     return d4;
        if (BYPASS && w3 && (a3 == a))     return d3;
        return stored;
    endfunction

    assign w3_ok = WE3 && live_addr(A3);
    assign w4_ok = WE4 && live_addr(A4);

    // Read-data selection: hardwired zero / out of range, then bypass, then storage.
    always_comb begin
        rd1_next = read_sel(A1, regs[A1], w3_ok, A3, WD3, w4_ok, A4, WD4);
        rd2_next = read_sel(A2, regs[A2], w3_ok, A3, WD3, w4_ok, A4, WD4);
    end

    // Register array update; port 4 is assigned last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w3_ok) regs[A3] <= WD3;
            if (w4_ok) regs[A4] <= WD4;
        end
    end

    // Registered read outputs, held while RE is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            RD1 <= '0;
            RD2 <= '0;
        end else if (RE) begin
            RD1 <= rd1_next;
            RD2 <= rd2_next;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] pending, pend_clr, pend_nxt;
    logic             hz1_next, hz2_next;

    // Pending bits: writebacks clear first, then an issue sets (issue wins).
    always_comb begin
        pend_clr = pending;
        if (w3_ok) pend_clr[A3] = 1'b0;
        if (w4_ok) pend_clr[A4] = 1'b0;
        pend_nxt = pend_clr;
        if (ISV && live_addr(ISA)) pend_nxt[ISA] = 1'b1;
        hz1_next = addr_ok(A1) ? pend_clr[A1] : 1'b0;
        hz2_next = addr_ok(A2) ? pend_clr[A2] : 1'b0;
    end

    // Scoreboard state and hazard flags aligned with RD1/RD2.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            HZ1     <= 1'b0;
            HZ2     <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (RE) begin
                HZ1 <= hz1_next;
                HZ2 <= hz2_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with a reference model and an
// expected-result queue; a write-first and a read-first instance share stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, RE, WE3, WE4;
    logic [4:0]  A1, A2, A3, A4;
    logic [31:0] WD3, WD4;
    logic [31:0] RD1, RD2, RF1, RF2;
`ifdef REGFILE_SCOREBOARD_EN
    logic        ISV;
    logic [4:0]  ISA;
    logic        HZ1, HZ2, HF1, HF2;
`endif

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .RE(RE), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
`ifdef REGFILE_SCOREBOARD_EN
        .ISV(ISV), .ISA(ISA), .HZ1(HZ1), .HZ2(HZ2),
`endif
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_rf (
        .clk(clk), .rst(rst), .RE(RE), .A1(A1), .A2(A2), .RD1(RF1), .RD2(RF2),
`ifdef REGFILE_SCOREBOARD_EN
        .ISV(ISV), .ISA(ISA), .HZ1(HF1), .HZ2(HF2),
`endif
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4)
    );

    typedef struct {
        logic [31:0] rd1, rd2, rf1, rf2;
        logic        hz1, hz2;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [31:0] model [32];
    logic        pend  [32];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && WE4 && A4 == a) return WD4;
        if (byp && WE3 && A3 == a) return WD3;
        return model[a];
    endfunction

    function automatic logic mhz(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if ((WE3 && A3 == a) || (WE4 && A4 == a)) return 1'b0;
        return pend[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RE = 1'b1; WE3 = 1'b0; WE4 = 1'b0;
        A3 = '0; A4 = '0; WD3 = '0; WD4 = '0;
`ifdef REGFILE_SCOREBOARD_EN
        ISV = 1'b0; ISA = '0;
`endif
    endtask

    // One clock: predict from current inputs, clock, update model, compare.
    task automatic cyc(input string tag);
        exp_t e;
        e = last;
        if (rst) begin
            e = '{rd1: 32'd0, rd2: 32'd0, rf1: 32'd0, rf2: 32'd0, hz1: 1'b0, hz2: 1'b0};
        end else if (RE) begin
            e.rd1 = mread(A1, 1'b1); e.rd2 = mread(A2, 1'b1);
            e.rf1 = mread(A1, 1'b0); e.rf2 = mread(A2, 1'b0);
            e.hz1 = mhz(A1);         e.hz2 = mhz(A2);
        end
        sb.push_back(e);
        last = e;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin model[i] = '0; pend[i] = 1'b0; end
        end else begin
            if (WE3 && A3 != 5'd0) begin model[A3] = WD3; pend[A3] = 1'b0; end
            if (WE4 && A4 != 5'd0) begin model[A4] = WD4; pend[A4] = 1'b0; end
`ifdef REGFILE_SCOREBOARD_EN
            if (ISV && ISA != 5'd0) pend[ISA] = 1'b1;
`endif
        end
        #1;
        e = sb.pop_front();
        chk({tag, ".RD1"},    RD1, e.rd1);
        chk({tag, ".RD2"},    RD2, e.rd2);
        chk({tag, ".RF.RD1"}, RF1, e.rf1);
        chk({tag, ".RF.RD2"}, RF2, e.rf2);
`ifdef REGFILE_SCOREBOARD_EN
        chk({tag, ".HZ1"}, {31'd0, HZ1}, {31'd0, e.hz1});
        chk({tag, ".HZ2"}, {31'd0, HZ2}, {31'd0, e.hz2});
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin model[i] = '0; pend[i] = 1'b0; end
        last = '{rd1: 32'd0, rd2: 32'd0, rf1: 32'd0, rf2: 32'd0, hz1: 1'b0, hz2: 1'b0};
        idle(); A1 = '0; A2 = '0;

        rst = 1'b1;                                   cyc("reset");
        rst = 1'b0; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; cyc("wr_x5");
        rst = 1'b1; WD3 = 32'hCAFEF00D; A2 = 5'd5;   cyc("rst_override");
        rst = 1'b0; idle(); A1 = 5'd5;               cyc("x5_after_rst");

        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h12345678;   cyc("wr_x7");
        idle(); A1 = 5'd7;                           cyc("rd_x7");

        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h11;
        WE4 = 1'b1; A4 = 5'd9; WD4 = 32'h22; A1 = 5'd9; cyc("dual_wr_bypass");
        idle();                                      cyc("x9_holds_p4");

        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; A2 = 5'd0; cyc("x0_write");
        idle();                                      cyc("x0_later");

        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hAA;
        WE4 = 1'b1; A4 = 5'd4; WD4 = 32'hBB;         cyc("wr_x3_x4");
        idle(); A1 = 5'd3;                           cyc("rd_x3");
        RE = 1'b0; A1 = 5'd4;
        WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h55;        cyc("stall_hold_wr");
        WE3 = 1'b0;                                  cyc("stall_hold");
        RE = 1'b1;                                   cyc("stall_release");
        A1 = 5'd10;                                  cyc("wr_during_stall");

        A1 = 5'd7; A2 = 5'd7;                        cyc("same_addr");
        WE3 = 1'b1; A3 = 5'd12; WD3 = 32'h77; A2 = 5'd12; cyc("p3_bypass");
        WE3 = 1'b0; WE4 = 1'b1; A4 = 5'd7; WD4 = 32'h99; A1 = 5'd7; A2 = 5'd12; cyc("p4_bypass");
        idle();                                      cyc("after_bypass");

`ifdef REGFILE_SCOREBOARD_EN
        ISV = 1'b1; ISA = 5'd6; A1 = 5'd6;           cyc("issue_x6");
        ISV = 1'b0;                                  cyc("hz_x6");
        WE4 = 1'b1; A4 = 5'd6; WD4 = 32'h66;         cyc("wb_x6_clears");
        idle(); ISV = 1'b1; ISA = 5'd8; WE3 = 1'b1; A3 = 5'd8; WD3 = 32'h88; cyc("issue_wins");
        idle(); A2 = 5'd8;                           cyc("hz_x8");
        ISV = 1'b1; ISA = 5'd0; A1 = 5'd0;           cyc("issue_x0");
        ISV = 1'b0;                                  cyc("hz_x0");
        RE = 1'b0; A2 = 5'd6;                        cyc("hz_hold");
        RE = 1'b1;                                   cyc("hz_release");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
